// File: rtl/tty_fb_writer_if.sv
`default_nettype none
// =============================================================================
// tty_fb_writer_if : character stream, hid_* frame-store bus and cursor status
// Rev 1.0
// =============================================================================
interface tty_fb_writer_if;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic [8:0]  ch_colour;
  logic        ch_ready;
  logic        busy;
  logic        hid_en;
  logic [7:0]  hid_we;
  logic [19:0] hid_addr;
  logic [63:0] hid_wrdata;
  logic [7:0]  one_hot_data_addr;
  logic [6:0]  x_pos;
  logic [5:0]  y_pos;

  // master: the writer, which owns the hid_* bus and consumes the character stream
  modport master (
    input  ch_valid, ch_data, ch_colour,
    output ch_ready, busy, hid_en, hid_we, hid_addr, hid_wrdata,
           one_hot_data_addr, x_pos, y_pos
  );

  modport slave (
    output ch_valid, ch_data, ch_colour,
    input  ch_ready, busy, hid_en, hid_we, hid_addr, hid_wrdata,
           one_hot_data_addr, x_pos, y_pos
  );
endinterface
`default_nettype wire

// File: rtl/tty_fb_writer.sv
`default_nettype none
// =============================================================================
// tty_fb_writer : glass-TTY writer turning a byte stream into text-cell writes
// Rev 1.0
// =============================================================================
module tty_fb_writer #(
  parameter int         COLS     = 128,
  parameter int         ROWS     = 32,
  parameter logic [6:0] CLR_CODE = 7'h20
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  tty_fb_writer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUT     = 3'd1,
    S_CLR_ROW = 3'd2,
    S_CLR_ALL = 3'd3,
    S_CUR_X   = 3'd4,
    S_CUR_Y   = 3'd5
  } state_e;

  localparam logic [6:0]  c_x_max    = 7'(COLS - 1);
  localparam logic [5:0]  c_y_max    = 6'(ROWS - 1);
  localparam logic [4:0]  c_w_max    = 5'(COLS / 4 - 1);
  localparam logic [19:0] c_cur_base = 20'h04000;

  state_e      state_q, state_d;
  logic [6:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic [4:0]  wcnt_q, wcnt_d;
  logic [5:0]  crow_q, crow_d;
  logic [6:0]  code_q, code_d;
  logic [8:0]  colour_q, colour_d;
  logic        adv_q, adv_d;

  logic        hid_en_q, hid_en_d;
  logic [7:0]  hid_we_q, hid_we_d;
  logic [19:0] hid_addr_q, hid_addr_d;
  logic [63:0] hid_wrdata_q, hid_wrdata_d;
  logic [7:0]  onehot_q, onehot_d;

  logic        w_accept;
  logic [6:0]  w_byte;
  logic [5:0]  w_y_wrap;

  assign bus.ch_ready          = (state_q == S_IDLE) && rst_ni;
  assign bus.busy              = (state_q != S_IDLE);
  assign bus.hid_en            = hid_en_q;
  assign bus.hid_we            = hid_we_q;
  assign bus.hid_addr          = hid_addr_q;
  assign bus.hid_wrdata        = hid_wrdata_q;
  assign bus.one_hot_data_addr = onehot_q;
  assign bus.x_pos             = x_q;
  assign bus.y_pos             = y_q;

  assign w_accept = bus.ch_valid && bus.ch_ready;
  assign w_byte   = bus.ch_data[6:0];
  assign w_y_wrap = (y_q == c_y_max) ? 6'd0 : y_q + 6'd1;

  // Cursor arithmetic happens on entry to the write state, so the write for a
  // state can be formed from the *_d values and registered alongside it.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    wcnt_d   = wcnt_q;
    crow_d   = crow_q;
    code_d   = code_q;
    colour_d = colour_q;
    adv_d    = adv_q;
    unique case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          colour_d = bus.ch_colour;
          state_d  = S_CUR_X;
          if (w_byte >= 7'h20 && w_byte <= 7'h7E) begin
            code_d  = w_byte;
            adv_d   = 1'b1;
            state_d = S_PUT;
          end else begin
            unique case (w_byte)
              7'h0D: x_d = 7'd0;
              7'h0A: begin
                x_d     = 7'd0;
                y_d     = w_y_wrap;
                wcnt_d  = 5'd0;
                state_d = S_CLR_ROW;
              end
              7'h08: begin
                if (x_q != 7'd0) begin
                  x_d     = x_q - 7'd1;
                  code_d  = CLR_CODE;
                  adv_d   = 1'b0;
                  state_d = S_PUT;
                end
              end
              7'h0C: begin
                crow_d  = 6'd0;
                wcnt_d  = 5'd0;
                state_d = S_CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      S_PUT: begin
        state_d = S_CUR_X;
        if (adv_q) begin
          if (x_q == c_x_max) begin
            x_d     = 7'd0;
            y_d     = w_y_wrap;
            wcnt_d  = 5'd0;
            state_d = S_CLR_ROW;
          end else begin
            x_d = x_q + 7'd1;
          end
        end
      end
      S_CLR_ROW: begin
        if (wcnt_q == c_w_max) state_d = S_CUR_X;
        else                   wcnt_d  = wcnt_q + 5'd1;
      end
      S_CLR_ALL: begin
        if (wcnt_q == c_w_max) begin
          wcnt_d = 5'd0;
          if (crow_q == c_y_max) begin
            x_d     = 7'd0;
            y_d     = 6'd0;
            state_d = S_CUR_X;
          end else begin
            crow_d = crow_q + 6'd1;
          end
        end else begin
          wcnt_d = wcnt_q + 5'd1;
        end
      end
      S_CUR_X: state_d = S_CUR_Y;
      S_CUR_Y: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hid_en_d     = 1'b0;
    hid_we_d     = 8'h00;
    hid_addr_d   = 20'h0;
    hid_wrdata_d = 64'h0;
    onehot_d     = 8'h00;
    unique case (state_d)
      S_PUT: begin
        hid_en_d     = 1'b1;
        hid_addr_d   = {1'b1, 5'b0, y_d, x_d[6:2], 3'b000};
        hid_we_d     = 8'h03 << {x_d[1:0], 1'b0};
        hid_wrdata_d = {4{colour_d, code_d}};
      end
      S_CLR_ROW: begin
        hid_en_d     = 1'b1;
        hid_addr_d   = {1'b1, 5'b0, y_d, wcnt_d, 3'b000};
        hid_we_d     = 8'hFF;
        hid_wrdata_d = {4{colour_d, CLR_CODE}};
      end
      S_CLR_ALL: begin
        hid_en_d     = 1'b1;
        hid_addr_d   = {1'b1, 5'b0, crow_d, wcnt_d, 3'b000};
        hid_we_d     = 8'hFF;
        hid_wrdata_d = {4{colour_d, CLR_CODE}};
      end
      S_CUR_X: begin
        hid_en_d     = 1'b1;
        hid_addr_d   = c_cur_base | {11'b0, 6'd2, 3'b000};
        hid_we_d     = 8'hFF;
        hid_wrdata_d = {57'b0, x_d};
        onehot_d     = 8'h80;
      end
      S_CUR_Y: begin
        hid_en_d     = 1'b1;
        hid_addr_d   = c_cur_base | {11'b0, 6'd3, 3'b000};
        hid_we_d     = 8'hFF;
        hid_wrdata_d = {58'b0, y_d};
        onehot_d     = 8'h80;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      x_q          <= 7'd0;
      y_q          <= 6'd0;
      wcnt_q       <= 5'd0;
      crow_q       <= 6'd0;
      code_q       <= 7'd0;
      colour_q     <= 9'd0;
      adv_q        <= 1'b0;
      hid_en_q     <= 1'b0;
      hid_we_q     <= 8'h00;
      hid_addr_q   <= 20'h0;
      hid_wrdata_q <= 64'h0;
      onehot_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      wcnt_q       <= wcnt_d;
      crow_q       <= crow_d;
      code_q       <= code_d;
      colour_q     <= colour_d;
      adv_q        <= adv_d;
      hid_en_q     <= hid_en_d;
      hid_we_q     <= hid_we_d;
      hid_addr_q   <= hid_addr_d;
      hid_wrdata_q <= hid_wrdata_d;
      onehot_q     <= onehot_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tty_fb_writer.sv
`default_nettype none
// =============================================================================
// tb_tty_fb_writer : directed vector bench for the glass-TTY frame-store writer
// Rev 1.0
// =============================================================================
module tb_tty_fb_writer;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  tty_fb_writer_if bif ();

  tty_fb_writer #(.COLS(128), .ROWS(32), .CLR_CODE(7'h20)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bif.master)
  );

  typedef struct {
    logic [19:0] a;
    logic [7:0]  we;
    logic [63:0] d;
    logic [7:0]  oh;
  } wr_t;
  wr_t wq[$];

  always @(negedge clk_i)
    if (bif.hid_en) wq.push_back('{bif.hid_addr, bif.hid_we, bif.hid_wrdata, bif.one_hot_data_addr});

  typedef struct {
    logic [7:0]  ch;
    logic [8:0]  col;
    int          lat;
    int          nwr;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [19:0] a0;
    logic [7:0]  we0;
    logic [15:0] c0;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [8:0] col, output int lat);
    int t = 0;
    @(negedge clk_i);
    while (!bif.ch_ready && t < 5000) begin
      @(negedge clk_i);
      t++;
    end
    if (!bif.ch_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_wait_ready: got 0 expected 1");
    end
    bif.ch_valid  = 1'b1;
    bif.ch_data   = c;
    bif.ch_colour = col;
    wq.delete();
    @(posedge clk_i); #1;
    bif.ch_valid = 1'b0;
    lat = 1;
    while (!bif.ch_ready && lat < 5000) begin
      @(posedge clk_i); #1;
      lat++;
    end
    if (!bif.ch_ready) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got 0 expected 1");
    end
  endtask

  task automatic chk_cursor(input string nm, input logic [6:0] x, input logic [5:0] y);
    int n = wq.size();
    if (n >= 2) begin
      chk({nm, "_curx_addr"}, 64'(wq[n-2].a), 64'h04010);
      chk({nm, "_curx_data"}, wq[n-2].d, {57'b0, x});
      chk({nm, "_curx_oh"}, 64'(wq[n-2].oh), 64'h80);
      chk({nm, "_cury_addr"}, 64'(wq[n-1].a), 64'h04018);
      chk({nm, "_cury_data"}, wq[n-1].d, {58'b0, y});
    end else begin
      chk({nm, "_cursor_writes"}, 64'(n), 64'd2);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    bif.ch_valid = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  vec_t vt[12];
  int   lat;
  int   errs;
  logic [15:0] c;

  initial begin
    bif.ch_valid  = 1'b0;
    bif.ch_data   = 8'h00;
    bif.ch_colour = 9'h000;

    // ---- reset state ----
    do_reset();
    chk("rst_ready", 64'(bif.ch_ready), 64'd0);
    chk("rst_busy", 64'(bif.busy), 64'd0);
    chk("rst_hid_en", 64'(bif.hid_en), 64'd0);
    chk("rst_hid_we", 64'(bif.hid_we), 64'd0);
    chk("rst_hid_addr", 64'(bif.hid_addr), 64'd0);
    chk("rst_hid_wrdata", bif.hid_wrdata, 64'd0);
    chk("rst_onehot", 64'(bif.one_hot_data_addr), 64'd0);
    chk("rst_x", 64'(bif.x_pos), 64'd0);
    chk("rst_y", 64'(bif.y_pos), 64'd0);
    @(negedge clk_i) rst_ni = 1'b1;

    // ---- table of single characters from (0,0) ----
    vt[0]  = '{8'h41, 9'h1FF, 4,  3, 7'd1, 6'd0, 20'h80000, 8'h03, 16'hFFC1};
    vt[1]  = '{8'h62, 9'h00A, 4,  3, 7'd2, 6'd0, 20'h80000, 8'h0C, 16'h0562};
    vt[2]  = '{8'hC3, 9'h1C0, 4,  3, 7'd3, 6'd0, 20'h80000, 8'h30, 16'hE043};
    vt[3]  = '{8'h44, 9'h007, 4,  3, 7'd4, 6'd0, 20'h80000, 8'hC0, 16'h03C4};
    vt[4]  = '{8'h45, 9'h000, 4,  3, 7'd5, 6'd0, 20'h80008, 8'h03, 16'h0045};
    vt[5]  = '{8'h0D, 9'h000, 3,  2, 7'd0, 6'd0, 20'h0,     8'h00, 16'h0000};
    vt[6]  = '{8'h07, 9'h000, 3,  2, 7'd0, 6'd0, 20'h0,     8'h00, 16'h0000};
    vt[7]  = '{8'h7F, 9'h000, 3,  2, 7'd0, 6'd0, 20'h0,     8'h00, 16'h0000};
    vt[8]  = '{8'h0A, 9'h111, 35, 34, 7'd0, 6'd1, 20'h80100, 8'hFF, 16'h88A0};
    vt[9]  = '{8'h08, 9'h000, 3,  2, 7'd0, 6'd1, 20'h0,     8'h00, 16'h0000};
    vt[10] = '{8'h46, 9'h1FF, 4,  3, 7'd1, 6'd1, 20'h80100, 8'h03, 16'hFFC6};
    vt[11] = '{8'h08, 9'h003, 4,  3, 7'd0, 6'd1, 20'h80100, 8'h03, 16'h01A0};

    for (int i = 0; i < 12; i++) begin
      send(vt[i].ch, vt[i].col, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("v%0d_nwrites", i), 64'(wq.size()), 64'(vt[i].nwr));
      chk($sformatf("v%0d_x", i), 64'(bif.x_pos), 64'(vt[i].x));
      chk($sformatf("v%0d_y", i), 64'(bif.y_pos), 64'(vt[i].y));
      if (vt[i].nwr > 2 && wq.size() > 2) begin
        c = vt[i].c0;
        chk($sformatf("v%0d_cell_addr", i), 64'(wq[0].a), 64'(vt[i].a0));
        chk($sformatf("v%0d_cell_we", i), 64'(wq[0].we), 64'(vt[i].we0));
        chk($sformatf("v%0d_cell_data", i), wq[0].d, {4{c}});
        chk($sformatf("v%0d_cell_oh", i), 64'(wq[0].oh), 64'd0);
      end
      chk_cursor($sformatf("v%0d", i), vt[i].x, vt[i].y);
    end

    // ---- 131 'B' from a fresh reset: wrap at column 127 ----
    do_reset();
    @(negedge clk_i) rst_ni = 1'b1;
    for (int i = 0; i < 131; i++) begin
      send(8'h42, 9'h000, lat);
      if (i == 127 && wq.size() == 35) begin
        chk("wrap_latency", 64'(lat), 64'd36);
        chk("wrap_cell_addr", 64'(wq[0].a), 64'h800F8);
        chk("wrap_cell_we", 64'(wq[0].we), 64'hC0);
        chk("wrap_clr_first", 64'(wq[1].a), 64'h80100);
        chk("wrap_clr_last", 64'(wq[32].a), 64'h801F8);
        chk("wrap_clr_data", wq[5].d, {4{16'h0020}});
        chk_cursor("wrap", 7'd0, 6'd1);
      end else if (i == 127) begin
        chk("wrap_nwrites", 64'(wq.size()), 64'd35);
      end
    end
    chk("b131_x", 64'(bif.x_pos), 64'd3);
    chk("b131_y", 64'(bif.y_pos), 64'd1);
    if (wq.size() > 0) begin
      chk("b131_last_addr", 64'(wq[0].a), 64'h80100);
      chk("b131_last_we", 64'(wq[0].we), 64'h30);
    end

    // ---- LF down to row 31, then LF wraps to top ----
    for (int i = 0; i < 30; i++) send(8'h0A, 9'h000, lat);
    chk("lf_row31_y", 64'(bif.y_pos), 64'd31);
    send(8'h0A, 9'h000, lat);
    chk("lf_wrap_y", 64'(bif.y_pos), 64'd0);
    chk("lf_wrap_x", 64'(bif.x_pos), 64'd0);
    chk("lf_wrap_latency", 64'(lat), 64'd35);
    chk("lf_wrap_nwrites", 64'(wq.size()), 64'd34);
    if (wq.size() == 34) begin
      chk("lf_wrap_first", 64'(wq[0].a), 64'h80000);
      chk("lf_wrap_last", 64'(wq[31].a), 64'h800F8);
    end

    // ---- backspace sequence ----
    send(8'h58, 9'h0F0, lat);
    send(8'h59, 9'h0F0, lat);
    send(8'h08, 9'h0F0, lat);
    chk("bs1_x", 64'(bif.x_pos), 64'd1);
    if (wq.size() == 3) begin
      chk("bs1_we", 64'(wq[0].we), 64'h0C);
      chk("bs1_data", wq[0].d, {4{16'h7820}});
    end else chk("bs1_nwrites", 64'(wq.size()), 64'd3);
    send(8'h08, 9'h0F0, lat);
    chk("bs2_x", 64'(bif.x_pos), 64'd0);
    if (wq.size() == 3) chk("bs2_we", 64'(wq[0].we), 64'h03);
    else chk("bs2_nwrites", 64'(wq.size()), 64'd3);
    send(8'h08, 9'h0F0, lat);
    chk("bs3_nwrites", 64'(wq.size()), 64'd2);
    chk("bs3_x", 64'(bif.x_pos), 64'd0);
    chk("bs3_latency", 64'(lat), 64'd3);
    chk_cursor("bs3", 7'd0, 6'd0);

    // ---- form feed clears the whole screen ----
    send(8'h51, 9'h000, lat);
    send(8'h0C, 9'h000, lat);
    chk("ff_latency", 64'(lat), 64'd1027);
    chk("ff_nwrites", 64'(wq.size()), 64'd1026);
    chk("ff_x", 64'(bif.x_pos), 64'd0);
    chk("ff_y", 64'(bif.y_pos), 64'd0);
    if (wq.size() == 1026) begin
      errs = 0;
      for (int i = 0; i < 1024; i++)
        if (wq[i].a !== 20'(20'h80000 + i * 8) || wq[i].we !== 8'hFF) errs++;
      chk("ff_sequence", 64'(errs), 64'd0);
      chk("ff_last_addr", 64'(wq[1023].a), 64'h81FF8);
      chk_cursor("ff", 7'd0, 6'd0);
    end

    // ---- reset in the middle of a screen clear ----
    send(8'h5A, 9'h000, lat);
    @(negedge clk_i);
    bif.ch_valid = 1'b1;
    bif.ch_data  = 8'h0C;
    @(posedge clk_i); #1;
    bif.ch_valid = 1'b0;
    repeat (300) @(posedge clk_i);
    #1;
    chk("midrst_pre_busy", 64'(bif.busy), 64'd1);
    chk("midrst_pre_x", 64'(bif.x_pos), 64'd1);
    @(negedge clk_i) rst_ni = 1'b0;
    @(posedge clk_i); #1;
    chk("midrst_hid_en", 64'(bif.hid_en), 64'd0);
    chk("midrst_x", 64'(bif.x_pos), 64'd0);
    chk("midrst_y", 64'(bif.y_pos), 64'd0);
    chk("midrst_busy", 64'(bif.busy), 64'd0);
    wq.delete();
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (100) @(posedge clk_i);
    #1;
    chk("midrst_no_writes", 64'(wq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
